// File: rtl/spu_add_arbiter.sv
// spu_add_arbiter: NUM requesters share one pipelined signed adder.
//   A round-robin arbiter issues at most one operand pair per cycle. A tag
//   pipeline (valid + requester id) runs in lockstep with the adder, so each
//   sum leaves on a single result stream tagged with its requester id.
//   Output backpressure and cke freeze the whole pipeline.
//
// Ports:
//   clk      clock
//   reset    asynchronous, active-low reset
//   cke      global clock enable; 0 freezes all state
//   s_valid  per-requester operand valid            [NUM]
//   s_ready  per-requester accept (grant)           [NUM]
//   s_data0  operand 0, requester i at [i*S_DATA0_BITS +: S_DATA0_BITS]
//   s_data1  operand 1, packed the same way
//   m_valid  result valid
//   m_ready  result accept
//   m_id     requester index of the result          [ID_BITS]
//   m_data   signed sum, wraps modulo 2^M_DATA_BITS [M_DATA_BITS]
//   busy     any pipeline stage holds a valid entry

// spu_add: signed adder with LATENCY register stages and active-high
// asynchronous reset. Operands are sign-extended (or truncated) to the
// result width before the add.
module spu_add #(
    parameter int S_DATA0_BITS = 8,
    parameter int S_DATA1_BITS = 8,
    parameter int M_DATA_BITS  = 9,
    parameter int LATENCY      = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cke,
    input  logic [S_DATA0_BITS-1:0] s_data0,
    input  logic [S_DATA1_BITS-1:0] s_data1,
    output logic [M_DATA_BITS-1:0]  m_data
);
    logic [M_DATA_BITS-1:0] w_a;
    logic [M_DATA_BITS-1:0] w_b;
    logic [M_DATA_BITS-1:0] r_stage [LATENCY];

    // A size cast of a signed value sign-extends when widening and truncates
    // when narrowing.
    assign w_a = M_DATA_BITS'($signed(s_data0));
    assign w_b = M_DATA_BITS'($signed(s_data1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else if (cke) begin
            r_stage[0] <= w_a + w_b;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign m_data = r_stage[LATENCY-1];
endmodule

module spu_add_arbiter #(
    parameter int NUM          = 4,
    parameter int ID_BITS      = $clog2(NUM),
    parameter int LATENCY      = 2,
    parameter int S_DATA0_BITS = 8,
    parameter int S_DATA1_BITS = 8,
    parameter int M_DATA_BITS  = 9
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cke,
    input  logic [NUM-1:0]              s_valid,
    output logic [NUM-1:0]              s_ready,
    input  logic [NUM*S_DATA0_BITS-1:0] s_data0,
    input  logic [NUM*S_DATA1_BITS-1:0] s_data1,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [ID_BITS-1:0]          m_id,
    output logic [M_DATA_BITS-1:0]      m_data,
    output logic                        busy
);
    if (LATENCY < 1) begin : g_bad_latency
        $error("spu_add_arbiter: LATENCY must be at least 1");
    end

    logic                    w_adv;
    logic                    w_any;
    logic [ID_BITS-1:0]      w_win;
    logic [ID_BITS-1:0]      w_ptr_next;
    logic                    w_add_rst;
    logic [S_DATA0_BITS-1:0] w_d0 [NUM];
    logic [S_DATA1_BITS-1:0] w_d1 [NUM];
    logic [ID_BITS-1:0]      r_ptr;
    logic [LATENCY-1:0]      r_tv;
    logic [ID_BITS-1:0]      r_tid [LATENCY];

    for (genvar g = 0; g < NUM; g++) begin : g_unpack
        assign w_d0[g] = s_data0[g*S_DATA0_BITS +: S_DATA0_BITS];
        assign w_d1[g] = s_data1[g*S_DATA1_BITS +: S_DATA1_BITS];
    end

    assign m_valid = r_tv[LATENCY-1];
    assign m_id    = r_tid[LATENCY-1];
    assign busy    = |r_tv;

    // The pipeline moves only when the output slot is empty or being drained.
    assign w_adv = cke & (~m_valid | m_ready);

    // Round-robin scan starting at the pointer, wrapping modulo NUM.
    always_comb begin
        logic [ID_BITS-1:0] w_idx;
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int unsigned k = 0; k < NUM; k++) begin
            w_idx = ID_BITS'((32'(r_ptr) + k) % NUM);
            if (!w_any && s_valid[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    always_comb begin
        s_ready = '0;
        if (w_adv && w_any) begin
            s_ready[w_win] = 1'b1;
        end
    end

    assign w_ptr_next = (w_win == ID_BITS'(NUM-1)) ? '0 : w_win + 1'b1;

    // Tag pipeline: shifts on the same enable as the adder so id and sum
    // always line up; bubbles shift through like valid entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tv  <= '0;
            r_ptr <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                r_tid[i] <= '0;
            end
        end else if (w_adv) begin
            r_tv[0]  <= w_any;
            r_tid[0] <= w_win;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_tv[i]  <= r_tv[i-1];
                r_tid[i] <= r_tid[i-1];
            end
            if (w_any) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    assign w_add_rst = ~reset;

    spu_add #(
        .S_DATA0_BITS (S_DATA0_BITS),
        .S_DATA1_BITS (S_DATA1_BITS),
        .M_DATA_BITS  (M_DATA_BITS),
        .LATENCY      (LATENCY)
    ) u_add (
        .clk     (clk),
        .reset   (w_add_rst),
        .cke     (w_adv),
        .s_data0 (w_d0[w_win]),
        .s_data1 (w_d1[w_win]),
        .m_data  (m_data)
    );

    // Requester protocol: a pending request holds valid and data until granted.
    for (genvar g = 0; g < NUM; g++) begin : g_proto
        a_hold : assert property (@(posedge clk) disable iff (!reset)
            (s_valid[g] && !s_ready[g]) |=>
            (s_valid[g] && $stable(w_d0[g]) && $stable(w_d1[g])));
    end
endmodule

// File: tb/tb_spu_add_arbiter.sv
module tb_spu_add_arbiter;
    localparam int NUM = 4;
    localparam int LAT = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             cke;
    logic             m_ready;
    logic [NUM-1:0]   s_valid;
    logic [NUM*8-1:0] s_data0;
    logic [NUM*8-1:0] s_data1;
    logic [NUM-1:0]   s_ready;
    logic             m_valid;
    logic [1:0]       m_id;
    logic [8:0]       m_data;
    logic             busy;
    logic [NUM-1:0]   s_ready8;
    logic             m_valid8;
    logic [1:0]       m_id8;
    logic [7:0]       m_data8;
    logic             busy8;

    always #5 clk = ~clk;

    spu_add_arbiter #(.NUM(NUM), .LATENCY(LAT), .S_DATA0_BITS(8),
                      .S_DATA1_BITS(8), .M_DATA_BITS(9)) dut (
        .clk(clk), .reset(reset), .cke(cke), .s_valid(s_valid), .s_ready(s_ready),
        .s_data0(s_data0), .s_data1(s_data1), .m_valid(m_valid), .m_ready(m_ready),
        .m_id(m_id), .m_data(m_data), .busy(busy));

    // Same traffic into an 8-bit result instance to observe wrap-around.
    spu_add_arbiter #(.NUM(NUM), .LATENCY(LAT), .S_DATA0_BITS(8),
                      .S_DATA1_BITS(8), .M_DATA_BITS(8)) dut8 (
        .clk(clk), .reset(reset), .cke(cke), .s_valid(s_valid), .s_ready(s_ready8),
        .s_data0(s_data0), .s_data1(s_data1), .m_valid(m_valid8), .m_ready(m_ready),
        .m_id(m_id8), .m_data(m_data8), .busy(busy8));

    typedef struct { bit v; int id; int sum; } ent_t;
    ent_t q[$];         // q[0] is the entry on the output
    int   ptr;
    bit   pend [NUM];
    byte  d0 [NUM];
    byte  d1 [NUM];
    int   waitg [NUM];  // grants to others since this request started
    int   e_win;
    bit   e_adv;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wrapm(input int s, input int bits);
        int m;
        int r;
        m = 1 << bits;
        r = s % m;
        if (r < 0) r += m;
        return r;
    endfunction

    task automatic model_reset();
        ent_t e;
        e.v = 0; e.id = 0; e.sum = 0;
        q.delete();
        repeat (LAT) q.push_back(e);
        ptr = 0;
        for (int i = 0; i < NUM; i++) begin
            pend[i] = 0;
            waitg[i] = 0;
        end
    endtask

    task automatic gen(input int p);
        for (int i = 0; i < NUM; i++) begin
            if (!pend[i] && $urandom_range(99) < p) begin
                pend[i]  = 1;
                d0[i]    = byte'($urandom);
                d1[i]    = byte'($urandom);
                waitg[i] = 0;
            end
        end
    endtask

    // Drive inputs at the falling edge, then compare outputs against the model.
    task automatic eval();
        int exp_ready;
        bit any_v;
        for (int i = 0; i < NUM; i++) begin
            s_valid[i]         = pend[i];
            s_data0[i*8 +: 8]  = d0[i];
            s_data1[i*8 +: 8]  = d1[i];
        end
        #1;
        e_adv = cke && (!q[0].v || m_ready);
        e_win = -1;
        for (int k = 0; k < NUM; k++) begin
            int idx;
            idx = (ptr + k) % NUM;
            if (e_win < 0 && pend[idx]) e_win = idx;
        end
        exp_ready = (e_adv && e_win >= 0) ? (1 << e_win) : 0;
        chk("s_ready", 32'(s_ready), exp_ready);
        chk("m_valid", 32'(m_valid), 32'(q[0].v));
        any_v = 0;
        foreach (q[i]) any_v |= q[i].v;
        chk("busy", 32'(busy), 32'(any_v));
        if (q[0].v) begin
            chk("m_id", 32'(m_id), q[0].id);
            chk("m_data", 32'(m_data), wrapm(q[0].sum, 9));
            chk("m_data8", 32'(m_data8), wrapm(q[0].sum, 8));
        end
    endtask

    // Apply what the next rising edge does, then move to the next falling edge.
    task automatic commit();
        ent_t e;
        if (e_adv) begin
            e.v   = (e_win >= 0);
            e.id  = (e_win >= 0) ? e_win : 0;
            e.sum = (e_win >= 0) ? int'(d0[e_win]) + int'(d1[e_win]) : 0;
            void'(q.pop_front());
            q.push_back(e);
            if (e_win >= 0) begin
                chk("fair", 32'(waitg[e_win] < NUM), 1);
                for (int i = 0; i < NUM; i++)
                    if (pend[i] && i != e_win) waitg[i]++;
                pend[e_win] = 0;
                ptr = (e_win + 1) % NUM;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n, input int p, input int p_rdy, input int cke_mode);
        for (int c = 0; c < n; c++) begin
            gen(p);
            m_ready = ($urandom_range(99) < p_rdy);
            case (cke_mode)
                0: cke = 1'b1;
                1: cke = c[0] ? 1'b0 : 1'b1;
                default: cke = ($urandom_range(99) < 75);
            endcase
            eval();
            commit();
        end
    endtask

    task automatic drain();
        int  n;
        bit  idle;
        n = 0;
        idle = 0;
        cke = 1'b1;
        m_ready = 1'b1;
        while (!idle && n < 60) begin
            eval();
            commit();
            idle = 1;
            foreach (q[i]) if (q[i].v) idle = 0;
            for (int i = 0; i < NUM; i++) if (pend[i]) idle = 0;
            n++;
        end
        chk("drain_timeout", 32'(idle), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        cke     = 1'b1;
        m_ready = 1'b1;
        s_valid = '0;
        s_data0 = '0;
        s_data1 = '0;
        model_reset();
        for (int i = 0; i < NUM; i++) begin d0[i] = 0; d1[i] = 0; end
        #1;
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_id", 32'(m_id), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Requester 2 alone: 5 + (-3) = 2, two cycles after issue.
        pend[2] = 1; d0[2] = 8'sd5; d1[2] = -8'sd3;
        eval();
        chk("t1_ready", 32'(s_ready), 32'b0100);
        commit();
        eval(); commit();
        eval();
        chk("t1_valid", 32'(m_valid), 1);
        chk("t1_id", 32'(m_id), 2);
        chk("t1_data", 32'(m_data), 2);
        commit();

        // 127 + 127: 254 in 9 bits, -2 wrapped in 8 bits.
        pend[1] = 1; d0[1] = 8'sd127; d1[1] = 8'sd127;
        eval(); commit();
        eval(); commit();
        eval();
        chk("ovf9", 32'(m_data), 254);
        chk("ovf8", 32'(m_data8), 32'h0FE);
        commit();
        drain();

        // Backpressure with two results in flight.
        pend[0] = 1; d0[0] = 8'sd10; d1[0] = 8'sd20;
        pend[1] = 1; d0[1] = -8'sd50; d1[1] = 8'sd7;
        eval(); commit();
        eval(); commit();
        m_ready = 1'b0;
        gen(100);
        for (int c = 0; c < 3; c++) begin
            eval();
            chk("bp_ready", 32'(s_ready), 0);
            chk("bp_busy", 32'(busy), 1);
            chk("bp_valid", 32'(m_valid), 1);
            commit();
        end
        drain();

        run(300, 100, 100, 0);   // all requesters continuously, full rate
        run(500, 50, 70, 0);     // random traffic and backpressure
        run(300, 60, 100, 1);    // cke toggling 1,0,1,0
        run(600, 40, 60, 2);     // everything random

        // Reset mid-stream with entries in flight.
        run(4, 100, 100, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(m_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        model_reset();
        s_valid = '0;
        @(negedge clk);
        reset = 1'b1;
        pend[0] = 1; d0[0] = 8'sd1; d1[0] = 8'sd2;
        pend[3] = 1; d0[3] = 8'sd3; d1[3] = 8'sd4;
        cke = 1'b1; m_ready = 1'b1;
        eval();
        chk("rst_first", 32'(s_ready), 32'b0001);
        commit();
        drain();
        run(200, 70, 80, 2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spu_add_arbiter.md
Name: spu_add_arbiter

Overview:
- Shares one pipelined signed adder (spu_add, fixed LATENCY) between NUM requesters, each with its own valid/ready operand channel.
- Round-robin grant issues at most one operand pair per cycle.
- A tag pipeline carries the requester id alongside the sum, so each result returns on a single output stream with its id.
- Output backpressure freezes the whole pipeline through cke.

Parameters:
- NUM, 4, number of requesters (2..16)
- ID_BITS, $clog2(NUM), width of the requester id
- LATENCY, 2, adder pipeline depth in cycles (>=1; 0 is illegal, elaboration error)
- S_DATA0_BITS, 8, operand 0 width, signed
- S_DATA1_BITS, 8, operand 1 width, signed
- M_DATA_BITS, 9, result width, signed

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cke  in  1  global clock enable; 0 freezes all state
- s_valid  in  NUM  per-requester operand valid
- s_ready  out  NUM  per-requester accept (grant)
- s_data0  in  NUM*S_DATA0_BITS  operand 0, requester i at slice [i*S_DATA0_BITS +: S_DATA0_BITS]
- s_data1  in  NUM*S_DATA1_BITS  operand 1, packed the same way
- m_valid  out  1  result valid
- m_ready  in  1  result accept
- m_id  out  ID_BITS  requester index of the result
- m_data  out  M_DATA_BITS  sum
- busy  out  1  1 when any pipeline stage holds a valid entry

Behaviour:
- Reset (reset=0, async):
  - All tag-valid stages clear; m_valid=0, m_id=0, m_data=0, busy=0.
  - RR pointer=0, so requester 0 has highest priority first.
  - The internal adder is reset through the inverted reset.
  - In-flight operations are discarded; nothing is replayed after reset release.
- Advance: adv = cke & (~m_valid | m_ready).
  - Adder cke = adv. The tag pipeline (valid + id, LATENCY stages) shifts only on adv.
  - The data and tag pipelines stay in lockstep at all times.
- Arbitration (combinational, same cycle):
  - Scan requesters starting at the pointer and wrap modulo NUM; the first with s_valid=1 wins.
  - s_ready[win] = adv. All other s_ready = 0. No requests or adv=0 gives s_ready all 0.
  - The winning operands enter the adder on this edge. Stage-0 tag = {1, win}; with no winner, stage-0 tag = {0, x}.
  - Pointer update: on an accepted grant (adv & any valid), pointer <= win+1 mod NUM. Otherwise it is unchanged.
- Throughput and latency:
  - Full throughput is one issue per cycle.
  - A result appears on m_valid exactly LATENCY advancing cycles after acceptance.
  - Bubbles travel through the pipeline; they do not collapse under stall.
- Output:
  - m_valid, m_id and m_data are the last pipeline stage.
  - While m_valid=1 & m_ready=0, all outputs hold stable and no new request is accepted.
  - m_valid=1 & m_ready=1 in the same cycle advances the pipeline and issues a new request (full rate under continuous ready).
- Arithmetic:
  - Operands are sign-extended to M_DATA_BITS, then added; the result wraps modulo 2^M_DATA_BITS.
  - If M_DATA_BITS is smaller than an operand width, that operand is truncated before the add.
- busy = OR of all tag-valid stages.
- cke=0: no state changes, s_ready all 0, outputs hold.
- Fairness: a requester holding s_valid high is granted within NUM accepted grants.
- Requester protocol: s_valid must not drop, and its data must not change, until the requester sees s_ready. This is checked by assertion only.

Test Plan:
- Reset, then requester 2 sends s_data0=5, s_data1=-3 with m_ready=1, cke=1, LATENCY=2 -> s_ready=4'b0100 in the issue cycle; 2 cycles later m_valid=1, m_id=2, m_data=2.
- All 4 requesters valid continuously, m_ready=1 -> grants in order 0,1,2,3,0,...; one result per cycle after LATENCY; ids match grant order.
- Overflow: s_data0=127, s_data1=127 (8-bit) -> m_data=254 (9-bit). Same pair with M_DATA_BITS=8 -> m_data=-2 (wrap).
- Backpressure: drop m_ready for 3 cycles while 2 results are in flight -> m_valid/m_id/m_data stable, s_ready all 0, busy=1; after m_ready=1 the results emerge in order with no loss or duplication.
- cke toggling 1,0,1,0 under continuous traffic -> the pipeline advances only on cke=1 cycles; result values and ids are unchanged versus the cke=1 run.
- Assert reset mid-stream with 2 entries in flight -> m_valid=0 and busy=0 immediately (async); after release requester 0 wins first and no stale results appear.
